// File: rtl/uart_digit_receiver.sv
// UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined) that parses "[-]d{1,4}<CR|LF>" frames
// into right-aligned BCD digits, a digit count and a sign flag for the seven-segment driver.
module uart_digit_receiver #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic [3:0] num4,
   output logic [3:0] n,
   output logic       sign,
   output logic       frameValid,
   output logic       frameError
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   // ------------------------------------------------------------------
   // Input synchronizer and falling-edge detect
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;
   logic rx_prev;
   logic rx_fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign rx_fall = rx_prev & ~rx_s;

   // ------------------------------------------------------------------
   // Bit engine
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_t;

   rx_state_t       rx_state;
   rx_state_t       rx_state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [2:0]      bit_idx;
   logic [2:0]      bit_idx_nxt;
   logic [7:0]      shreg;
   logic [7:0]      shreg_nxt;
   logic            par_bad;
   logic            par_bad_nxt;
   logic            byte_vld;
   logic            byte_err;
   logic [7:0]      byte_dat;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bad  <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
         par_bad  <= par_bad_nxt;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      cnt_nxt      = cnt + 1'b1;
      bit_idx_nxt  = bit_idx;
      shreg_nxt    = shreg;
      par_bad_nxt  = par_bad;
      byte_vld     = 1'b0;
      byte_err     = 1'b0;

      case (rx_state)
         RX_IDLE: begin
            cnt_nxt = '0;
            if (rx_fall) begin
               rx_state_nxt = RX_START;
               par_bad_nxt  = 1'b0;
            end
         end
         RX_START: begin
            // Mid-start-bit check rejects short low glitches silently.
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  rx_state_nxt = RX_IDLE;
               end else begin
                  rx_state_nxt = RX_DATA;
                  bit_idx_nxt  = '0;
               end
            end
         end
         RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt     = '0;
               shreg_nxt   = {rx_s, shreg[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                  rx_state_nxt = RX_PARITY;
`else
                  rx_state_nxt = RX_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         RX_PARITY: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt      = '0;
               par_bad_nxt  = ^{shreg, rx_s};
               rx_state_nxt = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt      = '0;
               rx_state_nxt = RX_IDLE;
               if (rx_s && !par_bad) begin
                  byte_vld = 1'b1;
               end else begin
                  byte_err = 1'b1;
               end
            end
         end
         default: begin
            rx_state_nxt = RX_IDLE;
         end
      endcase
   end

   assign byte_dat = shreg;

   // ------------------------------------------------------------------
   // Frame parser
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      P_EMPTY,
      P_DIGITS,
      P_SKIP
   } p_state_t;

   p_state_t    p_state;
   p_state_t    p_state_nxt;
   logic [2:0]  dcnt;
   logic [2:0]  dcnt_nxt;
   logic [15:0] dbuf;
   logic [15:0] dbuf_nxt;
   logic        psign;
   logic        psign_nxt;
   logic [15:0] disp;
   logic [15:0] disp_nxt;
   logic [3:0]  n_nxt;
   logic        sign_nxt;
   logic        valid_nxt;
   logic        err_nxt;

   logic        is_digit;
   logic        is_term;
   logic        is_minus;
   logic        is_clear;
   logic [3:0]  digit;

   assign is_digit = (byte_dat >= 8'h30) && (byte_dat <= 8'h39);
   assign is_term  = (byte_dat == 8'h0D) || (byte_dat == 8'h0A);
   assign is_minus = (byte_dat == 8'h2D);
   assign is_clear = (byte_dat == 8'h43);
   assign digit    = byte_dat[3:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         p_state    <= P_EMPTY;
         dcnt       <= '0;
         dbuf       <= '0;
         psign      <= 1'b0;
         disp       <= '0;
         n          <= '0;
         sign       <= 1'b0;
         frameValid <= 1'b0;
         frameError <= 1'b0;
      end else begin
         p_state    <= p_state_nxt;
         dcnt       <= dcnt_nxt;
         dbuf       <= dbuf_nxt;
         psign      <= psign_nxt;
         disp       <= disp_nxt;
         n          <= n_nxt;
         sign       <= sign_nxt;
         frameValid <= valid_nxt;
         frameError <= err_nxt;
      end
   end

   always_comb begin
      p_state_nxt = p_state;
      dcnt_nxt    = dcnt;
      dbuf_nxt    = dbuf;
      psign_nxt   = psign;
      disp_nxt    = disp;
      n_nxt       = n;
      sign_nxt    = sign;
      valid_nxt   = 1'b0;
      err_nxt     = 1'b0;

      if (byte_err) begin
         err_nxt     = 1'b1;
         p_state_nxt = P_SKIP;
      end else if (byte_vld) begin
         if (is_clear) begin
            p_state_nxt = P_EMPTY;
            dcnt_nxt    = '0;
            dbuf_nxt    = '0;
            psign_nxt   = 1'b0;
            disp_nxt    = '0;
            n_nxt       = '0;
            sign_nxt    = 1'b0;
         end else begin
            case (p_state)
               P_EMPTY: begin
                  if (is_minus) begin
                     psign_nxt   = 1'b1;
                     dcnt_nxt    = '0;
                     dbuf_nxt    = '0;
                     p_state_nxt = P_DIGITS;
                  end else if (is_digit) begin
                     psign_nxt   = 1'b0;
                     dcnt_nxt    = 3'd1;
                     dbuf_nxt    = {12'h000, digit};
                     p_state_nxt = P_DIGITS;
                  end else if (!is_term) begin
                     err_nxt     = 1'b1;
                     p_state_nxt = P_SKIP;
                  end
               end
               P_DIGITS: begin
                  // Shifting in at the low nibble keeps the number right-aligned.
                  if (is_digit) begin
                     if (dcnt != 3'd4) begin
                        dbuf_nxt = {dbuf[11:0], digit};
                        dcnt_nxt = dcnt + 3'd1;
                     end else begin
                        err_nxt     = 1'b1;
                        p_state_nxt = P_SKIP;
                     end
                  end else if (is_term) begin
                     if (dcnt != 3'd0) begin
                        disp_nxt  = dbuf;
                        n_nxt     = {1'b0, dcnt};
                        sign_nxt  = psign;
                        valid_nxt = 1'b1;
                     end
                     p_state_nxt = P_EMPTY;
                  end else begin
                     err_nxt     = 1'b1;
                     p_state_nxt = P_SKIP;
                  end
               end
               P_SKIP: begin
                  if (is_term) begin
                     p_state_nxt = P_EMPTY;
                  end
               end
               default: begin
                  p_state_nxt = P_EMPTY;
               end
            endcase
         end
      end
   end

   assign num1 = disp[15:12];
   assign num2 = disp[11:8];
   assign num3 = disp[7:4];
   assign num4 = disp[3:0];

endmodule

// File: tb/tb_uart_digit_receiver.sv
// Randomized bench for uart_digit_receiver: serial characters are driven on rxd and the display
// outputs and pulses are compared per character against a character-level frame model.
module tb_uart_digit_receiver;

   localparam int DIV = 16;
`ifdef RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       rxd;
   logic [3:0] num1;
   logic [3:0] num2;
   logic [3:0] num3;
   logic [3:0] num4;
   logic [3:0] n;
   logic       sign;
   logic       frame_valid;
   logic       frame_error;

   uart_digit_receiver #(
      .CLK_FREQ (16),
      .BAUD     (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rxd        (rxd),
      .num1       (num1),
      .num2       (num2),
      .num3       (num3),
      .num4       (num4),
      .n          (n),
      .sign       (sign),
      .frameValid (frame_valid),
      .frameError (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int v_cnt    = 0;
   int e_cnt    = 0;
   int both_cnt = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_valid) v_cnt++;
         if (frame_error) e_cnt++;
         if (frame_valid && frame_error) both_cnt++;
      end
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Frame-level reference model
   int m_dig[$];
   bit m_neg;
   bit m_open;
   bit m_skip;
   int e_num[4];
   int e_n;
   bit e_sign;

   task automatic model_frame_clear();
      m_dig.delete();
      m_neg  = 1'b0;
      m_open = 1'b0;
   endtask

   task automatic model_reset();
      model_frame_clear();
      m_skip = 1'b0;
      for (int k = 0; k < 4; k++) e_num[k] = 0;
      e_n    = 0;
      e_sign = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit bad, output int ev, output int ee);
      bit term;
      term = (b == 8'h0D) || (b == 8'h0A);
      ev = 0;
      ee = 0;
      if (bad) begin
         ee = 1;
         model_frame_clear();
         m_skip = 1'b1;
      end else if (b == 8'h43) begin
         model_reset();
      end else if (m_skip) begin
         if (term) begin
            m_skip = 1'b0;
            model_frame_clear();
         end
      end else if (term) begin
         if (m_dig.size() > 0) begin
            for (int k = 0; k < 4; k++) begin
               int idx;
               idx = m_dig.size() - 4 + k;
               e_num[k] = (idx >= 0) ? m_dig[idx] : 0;
            end
            e_n    = m_dig.size();
            e_sign = m_neg;
            ev     = 1;
         end
         model_frame_clear();
      end else if (b == 8'h2D && !m_open) begin
         m_neg  = 1'b1;
         m_open = 1'b1;
      end else if (b >= 8'h30 && b <= 8'h39 && m_dig.size() < 4) begin
         m_dig.push_back(int'(b) - 48);
         m_open = 1'b1;
      end else begin
         ee = 1;
         model_frame_clear();
         m_skip = 1'b1;
      end
   endtask

   task automatic chk_outs();
      chk_val("num1", num1, e_num[0]);
      chk_val("num2", num2, e_num[1]);
      chk_val("num3", num3, e_num[2]);
      chk_val("num4", num4, e_num[3]);
      chk_val("n", n, e_n);
      chk_val("sign", sign, e_sign);
   endtask

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (DIV) @(negedge clk);
   endtask

   // Sends one character, then compares pulses and outputs against the model.
   task automatic send_char(input logic [7:0] b, input bit bad_stop, input bit bad_par, input int gap);
      int v0, e0, ev, ee;
      v0 = v_cnt;
      e0 = e_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RX_PARITY_EN
      drive_bit((^b) ^ bad_par);
`endif
      drive_bit(!bad_stop);
      model_byte(b, bad_stop || (PAR_EN && bad_par), ev, ee);
      chk_val("valid_pulses", v_cnt - v0, ev);
      chk_val("error_pulses", e_cnt - e0, ee);
      chk_outs();
      rxd = 1'b1;
      repeat (gap + (bad_stop ? 4 : 0)) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      send_char(b, 1'b0, 1'b0, $urandom_range(0, 3));
   endtask

   function automatic logic [7:0] rand_term();
      return ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
   endfunction

   function automatic logic [7:0] rand_digit();
      return 8'h30 + 8'($urandom_range(0, 9));
   endfunction

   initial begin
      int v0, e0, kind, nd;
      reset = 1'b1;
      rxd   = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      chk_outs();
      chk_val("rst_valid", frame_valid, 0);
      chk_val("rst_error", frame_error, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // "123<CR>"
      send("1"); send("2"); send("3"); send(8'h0D);
      chk_val("tp1_n", n, 3);
      chk_val("tp1_num4", num4, 3);

      // "-4567<LF>"
      send("-"); send("4"); send("5"); send("6"); send("7"); send(8'h0A);
      chk_val("tp2_sign", sign, 1);
      chk_val("tp2_num1", num1, 4);

      // Overlong frame keeps previous result
      send("1"); send("2"); send("3"); send("4"); send("5"); send(8'h0D);
      chk_val("tp3_num4", num4, 7);

      // Short low glitch then idle
      v0 = v_cnt;
      e0 = e_cnt;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      chk_val("glitch_valid", v_cnt - v0, 0);
      chk_val("glitch_error", e_cnt - e0, 0);
      send("9"); send(8'h0D);
      chk_val("tp4_n", n, 1);
      chk_val("tp4_num4", num4, 9);

      // Framing error, discarded terminator, clear
      send_char("8", 1'b1, 1'b0, 2);
      send(8'h0D);
      send("C");
      chk_val("tp5_n", n, 0);

`ifdef RX_PARITY_EN
      send_char("7", 1'b0, 1'b1, 2);
      send(8'h0D);
      chk_val("par_bad_n", n, 0);
      send("7"); send(8'h0D);
      chk_val("par_ok_num4", num4, 7);
`endif

      // Lone minus and empty lines are silently discarded
      send("-"); send(8'h0D); send(8'h0A);

      // Reset in the middle of a character and frame
      send("5"); send("6"); send(8'h0D);
      send("1"); send("2");
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      reset = 1'b1;
      rxd   = 1'b1;
      @(negedge clk);
      model_reset();
      chk_outs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (DIV * 2) @(negedge clk);
      send(8'h0D);
      send("7"); send("7"); send(8'h0D);

      // Randomized frames
      for (int f = 0; f < 30; f++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2, 3, 4: begin
               if ($urandom_range(0, 1) != 0) send("-");
               nd = $urandom_range(1, 4);
               for (int i = 0; i < nd; i++) send(rand_digit());
               send(rand_term());
            end
            5: begin
               nd = $urandom_range(5, 6);
               for (int i = 0; i < nd; i++) send(rand_digit());
               send(rand_term());
            end
            6: begin
               send(8'($urandom_range(0, 255)));
               send(rand_term());
            end
            7: begin
               send(rand_digit());
               send_char(rand_digit(), 1'b1, 1'b0, $urandom_range(0, 3));
               send(rand_digit());
               send(rand_term());
            end
            8: begin
               send(rand_digit());
               send("C");
            end
            default: begin
               if ($urandom_range(0, 1) != 0) send("-");
               send(rand_term());
            end
         endcase
      end

      chk_val("pulse_overlap", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
